score_keeper: RTL and testbench

//  Game score state machine for Pong. Converts miss events from the ball/paddle

---
 rtl/pong_pkg.sv | 24 ++
 rtl/score_digit.sv | 33 +++
 rtl/score_keeper.sv | 184 ++++++++++++++++++
 tb/tb_score_keeper.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pong_pkg
//  Description : Shared state and winner encodings for the Pong score path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

    // Score-keeper game states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_PLAY  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // Winner codes reported while the game is over
    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_DRAW = 2'b11;

endpackage
`default_nettype wire

// File: rtl/score_digit.sv
`default_nettype none
// ============================================================================
//  Module      : score_digit
//  Description : One decimal score digit. Synchronous clear, increment that
//                saturates at a programmable maximum (never wraps).
//  Revision    : 1.0 - initial release
// ============================================================================
module score_digit (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic [3:0] max,
    output logic [3:0] q
);

    logic [3:0] r_q;

    // Digit register: clear wins over increment; increment holds at max
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= 4'd0;
        end else if (clr) begin
            r_q <= 4'd0;
        end else if (inc && (r_q < max)) begin
            r_q <= r_q + 4'd1;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : score_keeper
//  Description : Pong game score state machine. Turns miss events into
//                per-player decimal digits, sequences serve hold-off and
//                game over, and reports the winner.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 9,
    parameter int HOLDOFF_CYC = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    output logic [3:0] dig1,
    output logic [3:0] dig0,
    output logic       serve,
    output logic       playing,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam int               c_CNT_W  = $clog2(HOLDOFF_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_TERM = c_CNT_W'(HOLDOFF_CYC - 1);
    localparam logic [3:0]       c_WIN    = 4'(WIN_SCORE);
    localparam logic [3:0]       c_WIN_M1 = 4'(WIN_SCORE - 1);

    // Registered state
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_serve;
    logic [1:0]         r_winner;
    logic               r_p1_q;
    logic               r_p2_q;
    logic               r_ng_q;

    // Next-state / control
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_serve_nxt;
    logic [1:0]         w_winner_nxt;
    logic               w_clr;
    logic               w_inc1;
    logic               w_inc0;
    logic               w_p1_ev;
    logic               w_p2_ev;
    logic               w_ng_ev;
    logic               w_p1_wins;
    logic               w_p2_wins;

    // Rising-edge events; a held level acts only on its first cycle
    assign w_p1_ev = point_p1 & ~r_p1_q;
    assign w_p2_ev = point_p2 & ~r_p2_q;
    assign w_ng_ev = new_game & ~r_ng_q;

    // A player wins when this cycle's point lifts the digit to the target
    assign w_p1_wins = w_p1_ev && (dig1 == c_WIN_M1);
    assign w_p2_wins = w_p2_ev && (dig0 == c_WIN_M1);

    // Edge-detect history registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p1_q <= 1'b0;
            r_p2_q <= 1'b0;
            r_ng_q <= 1'b0;
        end else begin
            r_p1_q <= point_p1;
            r_p2_q <= point_p2;
            r_ng_q <= new_game;
        end
    end

    // FSM state, hold-off counter, serve pulse and winner registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_serve  <= 1'b0;
            r_winner <= W_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_serve  <= w_serve_nxt;
            r_winner <= w_winner_nxt;
        end
    end

    // Next-state logic; new_game always takes priority over point events
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_serve_nxt  = 1'b0;
        w_winner_nxt = r_winner;
        w_clr        = 1'b0;
        w_inc1       = 1'b0;
        w_inc0       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ng_ev) begin
                    w_clr        = 1'b1;
                    w_cnt_nxt    = '0;
                    w_winner_nxt = W_NONE;
                    w_state_nxt  = S_SERVE;
                end
            end
            S_SERVE: begin
                if (w_ng_ev) begin
                    w_clr       = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_TERM) begin
                    w_cnt_nxt   = '0;
                    w_serve_nxt = 1'b1;
                    w_state_nxt = S_PLAY;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
                end
            end
            S_PLAY: begin
                if (w_ng_ev) begin
                    w_clr       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SERVE;
                end else if (w_p1_ev || w_p2_ev) begin
                    w_inc1 = w_p1_ev;
                    w_inc0 = w_p2_ev;
                    if (w_p1_wins && w_p2_wins) begin
                        w_winner_nxt = W_DRAW;
                        w_state_nxt  = S_OVER;
                    end else if (w_p1_wins) begin
                        w_winner_nxt = W_P1;
                        w_state_nxt  = S_OVER;
                    end else if (w_p2_wins) begin
                        w_winner_nxt = W_P2;
                        w_state_nxt  = S_OVER;
                    end else begin
                        w_cnt_nxt    = '0;
                        w_state_nxt  = S_SERVE;
                    end
                end
            end
            S_OVER: begin
                if (w_ng_ev) begin
                    w_clr        = 1'b1;
                    w_cnt_nxt    = '0;
                    w_winner_nxt = W_NONE;
                    w_state_nxt  = S_SERVE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    score_digit u_dig1 (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_inc1),
        .max   (c_WIN),
        .q     (dig1)
    );

    score_digit u_dig0 (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .inc   (w_inc0),
        .max   (c_WIN),
        .q     (dig0)
    );

    assign serve     = r_serve;
    assign playing   = (r_state == S_PLAY);
    assign game_over = (r_state == S_OVER);
    assign winner    = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_keeper
//  Description : Self-checking bench for score_keeper (WIN_SCORE=3,
//                HOLDOFF_CYC=4). Vector table plus hand-written sequences;
//                expected outputs flow through a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_keeper;

    localparam int c_WIN     = 3;
    localparam int c_HOLDOFF = 4;

    logic       clk;
    logic       reset;
    logic       point_p1;
    logic       point_p2;
    logic       new_game;
    logic [3:0] dig1;
    logic [3:0] dig0;
    logic       serve;
    logic       playing;
    logic       game_over;
    logic [1:0] winner;

    // Expected output word: {dig1, dig0, serve, playing, game_over, winner}
    typedef struct packed {
        logic        p1;
        logic        p2;
        logic        ng;
        logic [12:0] exp;
    } vec_t;

    vec_t        vecs[$];
    logic [12:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;

    score_keeper #(
        .WIN_SCORE   (c_WIN),
        .HOLDOFF_CYC (c_HOLDOFF)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .point_p1  (point_p1),
        .point_p2  (point_p2),
        .new_game  (new_game),
        .dig1      (dig1),
        .dig0      (dig0),
        .serve     (serve),
        .playing   (playing),
        .game_over (game_over),
        .winner    (winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [12:0] ob(input int d1, input int d0, input logic srv,
                                       input logic ply, input logic ovr, input logic [1:0] w);
        return {4'(d1), 4'(d0), srv, ply, ovr, w};
    endfunction

    // Append one table vector
    function automatic void add(input logic p1, input logic p2, input logic ng,
                                input logic [12:0] e);
        vec_t v;
        v.p1  = p1;
        v.p2  = p2;
        v.ng  = ng;
        v.exp = e;
        vecs.push_back(v);
    endfunction

    // Remaining SERVE cycles after a point/new_game, then the serve pulse in PLAY
    function automatic void add_holdoff(input logic p1, input logic p2, input int d1, input int d0);
        for (int k = 0; k < c_HOLDOFF - 1; k++) add(p1, p2, 1'b0, ob(d1, d0, 0, 0, 0, 2'b00));
        add(p1, p2, 1'b0, ob(d1, d0, 1, 1, 0, 2'b00));
    endfunction

    // Pop one expected word and compare it with the current outputs
    task automatic check(input string name);
        logic [12:0] got;
        logic [12:0] e;
        got = {dig1, dig0, serve, playing, game_over, winner};
        e   = exp_q.pop_front();
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s @%0t: got d1=%0d d0=%0d srv=%b ply=%b ovr=%b win=%b, required d1=%0d d0=%0d srv=%b ply=%b ovr=%b win=%b",
                     name, $time, got[12:9], got[8:5], got[4], got[3], got[2], got[1:0],
                     e[12:9], e[8:5], e[4], e[3], e[2], e[1:0]);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic p1, input logic p2, input logic ng,
                        input logic [12:0] e, input string name);
        @(negedge clk);
        point_p1 = p1;
        point_p2 = p2;
        new_game = ng;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check(name);
    endtask

    // Watchdog: the run must never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset    = 1'b1;
        point_p1 = 1'b0;
        point_p2 = 1'b0;
        new_game = 1'b0;

        // Reset values before any clock edge
        #3;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 2'b00));
        check("reset_initial");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---- vector table ----
        // Start: 4 cycles of hold-off then one serve pulse, then plain play
        add(0, 0, 1, ob(0, 0, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 0, 0);
        add(0, 0, 0, ob(0, 0, 0, 1, 0, 2'b00));
        // point_p1 held 10 cycles counts once
        add(1, 0, 0, ob(1, 0, 0, 0, 0, 2'b00));
        add_holdoff(1, 0, 1, 0);
        for (int k = 0; k < 5; k++) add(1, 0, 0, ob(1, 0, 0, 1, 0, 2'b00));
        // Build up to 2-2
        add(0, 1, 0, ob(1, 1, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 1, 1);
        add(1, 0, 0, ob(2, 1, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 2, 1);
        add(0, 1, 0, ob(2, 2, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 2, 2);
        // Simultaneous winning points -> draw
        add(1, 1, 0, ob(3, 3, 0, 0, 1, 2'b11));
        add(1, 1, 0, ob(3, 3, 0, 0, 1, 2'b11));
        add(0, 0, 0, ob(3, 3, 0, 0, 1, 2'b11));
        // Restart from OVER, player 1 wins 3-0, later points ignored
        add(0, 0, 1, ob(0, 0, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 0, 0);
        add(1, 0, 0, ob(1, 0, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 1, 0);
        add(1, 0, 0, ob(2, 0, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 2, 0);
        add(1, 0, 0, ob(3, 0, 0, 0, 1, 2'b01));
        add(0, 0, 0, ob(3, 0, 0, 0, 1, 2'b01));
        add(0, 1, 0, ob(3, 0, 0, 0, 1, 2'b01));
        add(0, 0, 0, ob(3, 0, 0, 0, 1, 2'b01));
        add(0, 1, 0, ob(3, 0, 0, 0, 1, 2'b01));
        // Restart, reach 1-2 in PLAY
        add(0, 0, 1, ob(0, 0, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 0, 0);
        add(1, 0, 0, ob(1, 0, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 1, 0);
        add(0, 1, 0, ob(1, 1, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 1, 1);
        add(0, 1, 0, ob(1, 2, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 1, 2);
        // new_game beats a winning point_p2 in the same cycle
        add(0, 1, 1, ob(0, 0, 0, 0, 0, 2'b00));
        add(0, 0, 0, ob(0, 0, 0, 0, 0, 2'b00));
        add(0, 0, 0, ob(0, 0, 0, 0, 0, 2'b00));
        // new_game in SERVE restarts the hold-off counter
        add(0, 0, 1, ob(0, 0, 0, 0, 0, 2'b00));
        add_holdoff(0, 0, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].p1, vecs[i].p2, vecs[i].ng, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // ---- hand sequence: asynchronous reset in the middle of a game ----
        step(1, 0, 0, ob(1, 0, 0, 0, 0, 2'b00), "pre_reset_point");
        @(negedge clk);
        point_p1 = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 2'b00));
        check("async_reset_no_edge");
        @(posedge clk);
        #1;
        exp_q.push_back(ob(0, 0, 0, 0, 0, 2'b00));
        check("reset_held_edge");
        @(negedge clk);
        reset = 1'b0;
        // Points in IDLE are discarded
        step(1, 0, 0, ob(0, 0, 0, 0, 0, 2'b00), "idle_p1_a");
        step(0, 0, 0, ob(0, 0, 0, 0, 0, 2'b00), "idle_p1_b");
        step(1, 0, 0, ob(0, 0, 0, 0, 0, 2'b00), "idle_p1_c");
        step(0, 1, 0, ob(0, 0, 0, 0, 0, 2'b00), "idle_p2");
        // Next new_game edge starts the game again
        step(0, 0, 1, ob(0, 0, 0, 0, 0, 2'b00), "post_reset_ng");
        for (int k = 0; k < c_HOLDOFF - 1; k++)
            step(0, 0, 0, ob(0, 0, 0, 0, 0, 2'b00), "post_reset_wait");
        step(0, 0, 0, ob(0, 0, 1, 1, 0, 2'b00), "post_reset_serve");
        step(0, 0, 0, ob(0, 0, 0, 1, 0, 2'b00), "post_reset_play");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
